stream_mem_loader: RTL and testbench

//   Byte-stream boot loader that sits directly upstream of the bram32 write port.

---
 rtl/stream_mem_loader.sv | 149 ++++++++++++++
 tb/tb_stream_mem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mem_loader.sv
// Byte-stream boot loader: parses SYNC/LEN/ADR/data/CSUM frames from a valid/ready byte stream
// and issues single-cycle 32-bit word writes to a bram32 write port.
module stream_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_data,
  output logic                  o_mem_we,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    StIdle, StLen0, StLen1, StAdr0, StAdr1, StData, StCsum, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              hdr_lo_q, hdr_lo_d;
  logic [15:0]             word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [23:0]             asm_q, asm_d;
  logic [7:0]              csum_q, csum_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_data_q, mem_data_d;
  logic                    mem_we_q, mem_we_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    accept;
  logic [15:0]             hdr_word;

  assign o_ready    = (state_q != StDone);
  assign o_busy     = (state_q != StIdle);
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_we   = mem_we_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

  assign accept   = i_valid & o_ready;
  assign hdr_word = {i_data, hdr_lo_q};

  always_comb begin
    state_d    = state_q;
    hdr_lo_d   = hdr_lo_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;

    // Abort wins over any byte accepted in the same cycle; o_err is left untouched.
    if (i_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && i_data == SYNC_BYTE) begin
            state_d    = StLen0;
            err_d      = 1'b0;
            csum_d     = 8'h00;
            byte_cnt_d = 2'd0;
          end
        end
        StLen0: if (accept) begin
          hdr_lo_d = i_data;
          state_d  = StLen1;
        end
        StLen1: if (accept) begin
          word_cnt_d = hdr_word;
          state_d    = StAdr0;
        end
        StAdr0: if (accept) begin
          hdr_lo_d = i_data;
          state_d  = StAdr1;
        end
        StAdr1: if (accept) begin
          addr_d  = hdr_word[ADDR_WIDTH-1:0];
          state_d = (word_cnt_q != 16'd0) ? StData : StCsum;
        end
        StData: if (accept) begin
          csum_d     = csum_q ^ i_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_data_d = {i_data, asm_q};
            mem_addr_d = addr_q;
            mem_we_d   = 1'b1;
            addr_d     = addr_q + ADDR_WIDTH'(1);
            word_cnt_d = word_cnt_q - 16'd1;
            if (word_cnt_q == 16'd1) state_d = StCsum;
          end else begin
            asm_d[byte_cnt_q*8 +: 8] = i_data;
          end
        end
        StCsum: if (accept) begin
          err_d   = (i_data != csum_q);
          done_d  = 1'b1;
          state_d = StDone;
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      hdr_lo_q   <= 8'h00;
      word_cnt_q <= 16'd0;
      addr_q     <= '0;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      csum_q     <= 8'h00;
      mem_addr_q <= '0;
      mem_data_q <= 32'd0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_lo_q   <= hdr_lo_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_stream_mem_loader.sv
// Testbench for stream_mem_loader: table of frames plus hand-written abort/reset/junk sequences,
// with a write/done scoreboard checked by a negedge monitor.
module tb_stream_mem_loader;
  localparam int unsigned AW = 12;

  logic          clk;
  logic          rst_n;
  logic [7:0]    i_data;
  logic          i_valid;
  logic          o_ready;
  logic          i_abort;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_data;
  logic          o_mem_we;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  stream_mem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_abort    (i_abort),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_we   (o_mem_we),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] len;
    logic [15:0] adr;
    logic [31:0] w [4];
    logic [7:0]  flip;     // XORed into the correct checksum to force an error
    logic        exp_err;
  } frame_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t    exp_wr_q[$];
  logic   exp_done_q[$];
  wr_t    mon_e;
  logic   mon_err;
  int     checks = 0;
  int     errors = 0;
  int     stall_cnt = 0;
  frame_t frames [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_mem_we) begin
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", 32'(o_mem_addr), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_wr_q.pop_front();
          check("wr_addr", 32'(o_mem_addr), 32'(mon_e.addr));
          check("wr_data", o_mem_data, mon_e.data);
        end
      end
      if (o_done) begin
        check("done_ready_low", 32'(o_ready), 32'd0);
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_err = exp_done_q.pop_front();
          check("done_err", 32'(o_err), 32'(mon_err));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_data  = b;
    i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && n < 20) begin
      stall_cnt++;
      n++;
      @(negedge clk);
    end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input frame_t f);
    logic [7:0]  cs;
    logic [15:0] a;
    wr_t         e;
    cs = 8'h00;
    stall_cnt = 0;
    send_byte(8'hA5);
    check("err_clear_on_sync", 32'(o_err), 32'd0);
    send_byte(f.len[7:0]);
    send_byte(f.len[15:8]);
    send_byte(f.adr[7:0]);
    send_byte(f.adr[15:8]);
    for (int k = 0; k < int'(f.len); k++) begin
      a = f.adr + 16'(k);
      e.addr = a[AW-1:0];
      e.data = f.w[k];
      exp_wr_q.push_back(e);
      for (int j = 0; j < 4; j++) begin
        cs = cs ^ f.w[k][8*j +: 8];
        send_byte(f.w[k][8*j +: 8]);
      end
    end
    exp_done_q.push_back(f.exp_err);
    send_byte(cs ^ f.flip);
    i_valid = 1'b0;
    check("no_stall", 32'(stall_cnt), 32'd0);
    idle(3);
    check("idle_after_frame", 32'(o_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
    check({tag, "_data"}, o_mem_data, 32'd0);
    check({tag, "_we"}, 32'(o_mem_we), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    frames[0] = '{len: 16'd1, adr: 16'h0010, w: '{32'hDEADBEEF, 0, 0, 0}, flip: 8'h00, exp_err: 1'b0};
    frames[1] = '{len: 16'd3, adr: 16'h0FFF,
                  w: '{32'h0403_0201, 32'hA0B0_C0D0, 32'h1234_5678, 0}, flip: 8'h00, exp_err: 1'b0};
    frames[2] = '{len: 16'd1, adr: 16'h0010, w: '{32'hDEADBEEF, 0, 0, 0}, flip: 8'h22, exp_err: 1'b1};
    frames[3] = '{len: 16'd0, adr: 16'h0000, w: '{0, 0, 0, 0}, flip: 8'h00, exp_err: 1'b0};
    frames[4] = '{len: 16'd2, adr: 16'h1234,
                  w: '{32'hCAFE_F00D, 32'h0BAD_C0DE, 0, 0}, flip: 8'h00, exp_err: 1'b0};

    i_data  = 8'h00;
    i_valid = 1'b0;
    i_abort = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        send_byte(8'h00);
        send_byte(8'h5A);
        idle(2);
        check("junk_ignored", 32'(o_busy), 32'd0);
      end
      if (i > 0) check("err_held", 32'(o_err), 32'(frames[i-1].exp_err));
      send_frame(frames[i]);
    end

    // Abort after two of four data bytes: no write, no done.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'hEF);
    send_byte(8'hBE);
    i_valid = 1'b0;
    i_abort = 1'b1;
    @(posedge clk);
    #1;
    i_abort = 1'b0;
    check("abort_idle", 32'(o_busy), 32'd0);
    idle(3);
    check("abort_no_done", 32'(exp_done_q.size()), 32'd0);
    send_frame(frames[4]);

    // Reset in the middle of DATA after one word was written.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h00);
    e.addr = 12'h020;
    e.data = 32'h4433_2211;
    exp_wr_q.push_back(e);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_frame(frames[0]);

    idle(5);
    check("pending_writes", 32'(exp_wr_q.size()), 32'd0);
    check("pending_done", 32'(exp_done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
